// File: rtl/prog_rom_if.sv
// Bus bundle for prog_rom: fetch-side read port, write port and the
// byte-stream loader source. The master drives requests, the slave is the ROM.
interface prog_rom_if #(
   parameter int DW     = 32,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 13
);
   // write port
   logic              w_en;
   logic [ADDR_W-1:0] w_addr_i;
   logic [DW-1:0]     w_data_i;
   logic [DW/8-1:0]   w_strb_i;
   logic              w_err_o;
   // read port
   logic              r_en;
   logic [ADDR_W-1:0] r_addr_i;
   logic [DW-1:0]     r_data_o;
   logic              r_valid_o;
   logic              r_err_o;
   // loader stream
   logic              ld_start_i;
   logic [ADDR_W-1:0] ld_base_i;
   logic [LEN_W-1:0]  ld_len_i;
   logic              ld_byte_valid_i;
   logic [7:0]        ld_byte_i;
   logic              ld_byte_ready_o;
   logic              ld_busy_o;
   logic              ld_done_o;
   logic              ld_err_o;

   modport master (
      output w_en, w_addr_i, w_data_i, w_strb_i,
      output r_en, r_addr_i,
      output ld_start_i, ld_base_i, ld_len_i, ld_byte_valid_i, ld_byte_i,
      input  w_err_o, r_data_o, r_valid_o, r_err_o,
      input  ld_byte_ready_o, ld_busy_o, ld_done_o, ld_err_o
   );

   modport slave (
      input  w_en, w_addr_i, w_data_i, w_strb_i,
      input  r_en, r_addr_i,
      input  ld_start_i, ld_base_i, ld_len_i, ld_byte_valid_i, ld_byte_i,
      output w_err_o, r_data_o, r_valid_o, r_err_o,
      output ld_byte_ready_o, ld_busy_o, ld_done_o, ld_err_o
   );
endinterface

// File: rtl/prog_rom.sv
// Dual-port program memory for instruction fetch. Byte-addressed ports are
// translated to word indices; reads return one cycle later with write-first
// bypass. A small loader FSM packs a little-endian byte stream into words.
module prog_rom #(
   parameter int DW      = 32,
   parameter int AW      = 12,
   parameter int MEM_NUM = 4096,
   parameter int ADDR_W  = 32,
   parameter int LEN_W   = 13
) (
   input logic       clk,
   input logic       rst,
   prog_rom_if.slave bus
);
   localparam int NB = DW / 8;
   localparam int OB = $clog2(NB);
   // wide enough for base + word count without wrapping
   localparam int TW = ((AW > LEN_W) ? AW : LEN_W) + 1;
   localparam logic [TW-1:0] MEM_LIMIT = TW'(MEM_NUM);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} ld_state_e;

   // misaligned, bits above the index field, or beyond the implemented words
   function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] hi;
      hi = addr >> (OB + AW);
      return (addr[OB-1:0] != '0) || (hi != '0) ||
             (TW'(addr[OB+AW-1:OB]) >= MEM_LIMIT);
   endfunction

   function automatic logic [AW-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
      return addr[OB+AW-1:OB];
   endfunction

   logic [DW-1:0]    r_mem [MEM_NUM];

   ld_state_e        r_state;
   ld_state_e        w_state_next;
   logic [AW-1:0]    r_base;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_wcnt;
   logic [OB-1:0]    r_bcnt;
   logic [DW-1:0]    r_word;
   logic             r_ld_err;

   logic [DW-1:0]    r_rd_data;
   logic             r_rd_valid;
   logic             r_rd_err;
   logic             r_wr_err;

   logic             w_ext_wr;
   logic             w_ext_bad;
   logic             w_rd_bad;
   logic [AW-1:0]    w_rd_idx;
   logic [DW-1:0]    w_rd_word;

   logic             w_accept;
   logic             w_ld_wr;
   logic             w_ld_abort;
   logic             w_ld_start_bad;
   logic             w_ld_start_go;
   logic [TW-1:0]    w_tgt;
   logic [AW-1:0]    w_ld_idx;
   logic [DW-1:0]    w_word_next;

   logic             w_wr_en;
   logic [AW-1:0]    w_wr_idx;
   logic [DW-1:0]    w_wr_data;
   logic [NB-1:0]    w_wr_strb;

   // the external write port is locked out while the loader owns the memory
   assign w_ext_wr  = bus.w_en && (r_state != S_LOAD);
   assign w_ext_bad = addr_bad(bus.w_addr_i);
   assign w_rd_bad  = addr_bad(bus.r_addr_i);
   assign w_rd_idx  = addr_idx(bus.r_addr_i);

   // loader next-state and byte/word handling
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_state_next   = r_state;
      w_accept       = 1'b0;
      w_ld_wr        = 1'b0;
      w_ld_abort     = 1'b0;
      w_ld_start_bad = 1'b0;
      w_ld_start_go  = 1'b0;
      w_word_next    = r_word;
      w_tgt          = TW'(r_base) + TW'(r_wcnt);
      w_ld_idx       = w_tgt[AW-1:0];
      case (r_state)
         S_IDLE: begin
            if (bus.ld_start_i) begin
               if (addr_bad(bus.ld_base_i)) begin
                  w_ld_start_bad = 1'b1;
               end else if (bus.ld_len_i == '0) begin
                  w_state_next = S_DONE;
               end else begin
                  w_ld_start_go = 1'b1;
                  w_state_next  = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (bus.ld_byte_valid_i) begin
               w_accept = 1'b1;
               w_word_next[{r_bcnt, 3'b000} +: 8] = bus.ld_byte_i;
               if (r_bcnt == OB'(NB - 1)) begin
                  if (w_tgt >= MEM_LIMIT) begin
                     w_ld_abort   = 1'b1;
                     w_state_next = S_IDLE;
                  end else begin
                     w_ld_wr = 1'b1;
                     if (r_wcnt + LEN_W'(1) == r_len) begin
                        w_state_next = S_DONE;
                     end
                  end
               end
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // single write port: loader word writes, else good external writes
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_idx  = '0;
      w_wr_data = '0;
      w_wr_strb = '0;
      if (w_ld_wr) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = w_ld_idx;
         w_wr_data = w_word_next;
         w_wr_strb = '1;
      end else if (w_ext_wr && !w_ext_bad) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = addr_idx(bus.w_addr_i);
         w_wr_data = bus.w_data_i;
         w_wr_strb = bus.w_strb_i;
      end
   end

   // write-first read: stored word overlaid with lanes being written this cycle
   always_comb begin
      w_rd_word = r_mem[w_rd_idx];
      for (int k = 0; k < NB; k++) begin
         if (w_wr_en && (w_wr_idx == w_rd_idx) && w_wr_strb[k]) begin
            w_rd_word[8*k +: 8] = w_wr_data[8*k +: 8];
         end
      end
   end

   // memory array: per-lane writes
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset so it maps onto RAM; contents survive rst by design.
      if (w_wr_en) begin
         for (int k = 0; k < NB; k++) begin
            if (w_wr_strb[k]) begin
               r_mem[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
            end
         end
      end
   end

   // read response and write-error pulse registers
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         r_rd_valid <= bus.r_en;
         r_rd_err   <= bus.r_en && w_rd_bad;
         r_wr_err   <= w_ext_wr && w_ext_bad;
         if (bus.r_en) begin
            r_rd_data <= w_rd_bad ? '0 : w_rd_word;
         end
      end
   end

   // loader state register with its counters and partial word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_len    <= '0;
         r_wcnt   <= '0;
         r_bcnt   <= '0;
         r_word   <= '0;
         r_ld_err <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_ld_err <= w_ld_start_bad || w_ld_abort;
         if (w_ld_start_go) begin
            r_base <= addr_idx(bus.ld_base_i);
            r_len  <= bus.ld_len_i;
            r_wcnt <= '0;
            r_bcnt <= '0;
            r_word <= '0;
         end else if (w_accept) begin
            r_bcnt <= r_bcnt + OB'(1);
            r_word <= (w_ld_wr || w_ld_abort) ? '0 : w_word_next;
            if (w_ld_wr) begin
               r_wcnt <= r_wcnt + LEN_W'(1);
            end
         end
      end
   end

   assign bus.r_data_o        = r_rd_data;
   assign bus.r_valid_o       = r_rd_valid;
   assign bus.r_err_o         = r_rd_err;
   assign bus.w_err_o         = r_wr_err;
   assign bus.ld_byte_ready_o = (r_state == S_LOAD);
   assign bus.ld_busy_o       = (r_state == S_LOAD);
   assign bus.ld_done_o       = (r_state == S_DONE);
   assign bus.ld_err_o        = r_ld_err;
endmodule
